ne_seq_ctrl: RTL

Sequencer for one NEwithDAA neuron-element datapath. Accepts a job (term count, signedness, save slot) and a valid/ready stream of 4-bit activation / 3-bit Booth weight pairs. Drives the datapath through clear, multiply-accumulate, pipeline drain and normalise/save phases, then reads back the 10-bit result and 3-bit exponent over the `InputSel` mux and presents them on a valid/ready output port. Sits between the operand source (scratchpad/host logic) and the datapath instance in the user project top.

---
 rtl/ne_seq_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/ne_seq_ctrl.sv
// ne_seq_ctrl: job sequencer for one NEwithDAA neuron-element datapath.
//   Runs each job through clear, multiply-accumulate, pipeline drain and
//   normalise/save, then reads back the result and exponent over InputSel.
//   clk, rst              clock, asynchronous active-high reset
//   start, cfg_len,       job request (sampled in IDLE only), term count
//   cfg_signed, cfg_ep    (clamped to 16), SignExEn level, save slot
//   in_valid/in_ready,    operand stream: 4-bit activation, 3-bit Booth digit
//   in_act, in_w
//   ne_*                  datapath controls and operands; ne_o readback mux
//   res_valid/res_ready,  captured result and exponent, held until accepted
//   res_data, res_exp
//   busy, done            busy outside IDLE; done pulses on result handshake
module ne_seq_ctrl #(
    parameter int DRAIN_CYC = 3,
    parameter int NORM_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] cfg_len,
    input  logic       cfg_signed,
    input  logic [3:0] cfg_ep,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_act,
    input  logic [2:0] in_w,
    output logic [3:0] ne_InPE,
    output logic [2:0] ne_w,
    output logic       ne_enable,
    output logic       ne_clear,
    output logic       ne_NEP,
    output logic       ne_SignExEn,
    output logic [3:0] ne_EPcount,
    output logic [1:0] ne_InputSel,
    input  logic [9:0] ne_o,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [9:0] res_data,
    output logic [2:0] res_exp,
    output logic       busy,
    output logic       done
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] MAC    = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] NORM   = 3'd4;
    localparam logic [2:0] RD_RES = 3'd5;
    localparam logic [2:0] RD_EXP = 3'd6;
    localparam logic [2:0] OUT    = 3'd7;
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);
    localparam logic [3:0] NORM_LAST  = 4'(NORM_CYC - 1);

    logic [2:0] state, nxt;
    logic [4:0] cnt;
    logic [3:0] ph;
    logic [3:0] ep;
    logic       en_r;
    logic       in_mac;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? CLEAR : IDLE;
            CLEAR:   nxt = cnt == 5'd0 ? DRAIN : MAC;
            MAC:     nxt = in_valid && cnt == 5'd1 ? DRAIN : MAC;
            DRAIN:   nxt = ph == 4'd0 ? NORM : DRAIN;
            NORM:    nxt = ph == 4'd0 ? RD_RES : NORM;
            RD_RES:  nxt = RD_EXP;
            RD_EXP:  nxt = OUT;
            default: nxt = res_ready ? IDLE : OUT;
        endcase
    end

    // Controls are computed from the next state so they are flops that line
    // up with the state they belong to; only the MAC operand path is combinational.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            ph          <= 4'd0;
            ep          <= 4'd0;
            en_r        <= 1'b0;
            ne_clear    <= 1'b0;
            ne_NEP      <= 1'b0;
            ne_EPcount  <= 4'd0;
            ne_InputSel <= 2'b00;
            ne_SignExEn <= 1'b0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            res_data    <= 10'd0;
            res_exp     <= 3'd0;
        end else begin
            state       <= nxt;
            cnt         <= state == IDLE ? (cfg_len > 5'd16 ? 5'd16 : cfg_len)
                         : in_mac && in_valid ? cnt - 5'd1 : cnt;
            ph          <= nxt == DRAIN && state != DRAIN ? DRAIN_LAST
                         : nxt == NORM && state != NORM ? NORM_LAST : ph - 4'd1;
            ep          <= state == IDLE && start ? cfg_ep : ep;
            en_r        <= nxt == CLEAR || nxt == DRAIN || nxt == NORM;
            ne_clear    <= nxt == CLEAR;
            ne_NEP      <= nxt == NORM;
            ne_EPcount  <= nxt == NORM ? ep : 4'd0;
            ne_InputSel <= nxt == RD_EXP ? 2'b01 : 2'b00;
            ne_SignExEn <= nxt == IDLE ? 1'b0 : state == IDLE ? cfg_signed : ne_SignExEn;
            res_valid   <= nxt == OUT;
            busy        <= nxt != IDLE;
            res_data    <= state == RD_RES ? ne_o : res_data;
            res_exp     <= state == RD_EXP ? ne_o[2:0] : res_exp;
        end
    end

    assign in_mac    = state == MAC;
    assign in_ready  = in_mac;
    assign ne_enable = in_mac ? in_valid : en_r;
    assign ne_InPE   = in_mac ? in_act : 4'd0;
    assign ne_w      = in_mac ? in_w : 3'd0;
    assign done      = res_valid && res_ready;
endmodule
